// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage request/response bundle between the pipeline and the SRAM controller
//
// Signals:
//   wr_en      store request, level, held while ready=0
//   rd_en      load request, level, held while ready=0
//   address    byte address from the ALU result (data segment starts at 1024)
//   writeData  store data (Val_Rm)
//   readData   registered load result
//   ready      access complete; the pipeline freezes on ~ready
// Modports: master = pipeline MEM stage, slave = sram_controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output writeData,
        input  readData,
        input  ready
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  writeData,
        output readData,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM in two half-word beats
//
// Ports:
//   clk        rising-edge clock shared with the pipeline registers
//   rst_n      asynchronous active-low reset
//   bus        sram_controller_if.slave: wr_en, rd_en, address, writeData in; readData, ready out
//   SRAM_DQ    16-bit bidirectional SRAM data bus (driven only during the two write beats)
//   SRAM_ADDR  18-bit SRAM half-word address {word address, half select}
//   SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  active-low SRAM strobes
//
// Every access takes seven cycles: IDLE (request seen), LO, HI, W1, W2, W3, DONE.
// ready is low from the IDLE-detect cycle through W3 and high only in DONE, so the
// pipeline advances at the edge that ends DONE.
module sram_controller (
    input  logic              clk,
    input  logic              rst_n,
    sram_controller_if.slave  bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    localparam logic [31:0] DATA_BASE = 32'd1024;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        W1,
        W2,
        W3,
        DONE
    } state_t;

    state_t      state;
    logic        op_write;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] read_q;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        req;
    logic [16:0] waddr_in;
    logic [16:0] waddr_q;

    assign req = bus.rd_en | bus.wr_en;

    // Word address inside the data segment. Addresses below the segment base
    // simply wrap modulo 2^17; no error is reported.
    assign waddr_in = 17'((bus.address - DATA_BASE) >> 2);
    assign waddr_q  = 17'((addr_q - DATA_BASE) >> 2);

    // Write data: low half is on the bus during LO, high half during HI.
    assign dq_out  = (state == HI) ? data_q[31:16] : data_q[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // In IDLE the stall must appear in the same cycle the request does, hence
    // the combinational path from the request lines.
    assign bus.ready    = (state == IDLE) ? ~req : (state == DONE);
    assign bus.readData = read_q;

    // Strobes and address are registered together with the state so that they
    // change exactly at the state boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            read_q    <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b0;
            dq_oe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both requests are present.
                        op_write  <= bus.wr_en;
                        addr_q    <= bus.address;
                        data_q    <= bus.writeData;
                        SRAM_ADDR <= {waddr_in, 1'b0};
                        SRAM_WE_N <= ~bus.wr_en;
                        SRAM_OE_N <= bus.wr_en;
                        dq_oe     <= bus.wr_en;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (!op_write) begin
                        read_q[15:0] <= SRAM_DQ;
                    end
                    SRAM_ADDR <= {waddr_q, 1'b1};
                    state     <= HI;
                end
                HI: begin
                    if (!op_write) begin
                        read_q[31:16] <= SRAM_DQ;
                    end
                    // Release the bus and return the SRAM to output-enabled idle.
                    SRAM_WE_N <= 1'b1;
                    SRAM_OE_N <= 1'b0;
                    dq_oe     <= 1'b0;
                    state     <= W1;
                end
                W1:      state <= W2;
                W2:      state <= W3;
                W3:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with SRAM model and word-level reference
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst_n;

    sram_controller_if bus ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    sram_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Physical SRAM: drives the bus when output-enabled and not writing,
    // stores the bus at a clock edge while WE_N is low.
    logic [15:0] sram_mem [0:262143];
    logic [15:0] sram_q;
    assign sram_q  = sram_mem[sram_addr];
    assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_q : 16'hzzzz;

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        forever begin
            @(posedge clk);
            if (!sram_we_n && !sram_ce_n) sram_mem[sram_addr] = sram_dq;
        end
    end

    // Word-level reference: 32-bit words keyed by the segment word index.
    logic [31:0] ref_mem [logic [16:0]];

    function automatic logic [16:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [16:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    // Model: m_pos = -1 while idle, otherwise the cycle index within the
    // 7-cycle access (1 = low half, 2 = high half, 6 = completion cycle).
    int          m_pos = -1;
    logic        m_wr = 1'b0;
    logic [16:0] m_wa = '0;
    logic [31:0] m_d = '0;
    logic [31:0] exp_rd = '0;

    always @(posedge clk or negedge clk) begin
        logic        wphase;
        logic [31:0] word;
        if (clk == 1'b0) begin
            if (!rst_n) begin
                m_pos  = -1;
                exp_rd = '0;
                chk("rst_readData", bus.readData, 32'h0);
                chk("rst_we_n", 32'(sram_we_n), 32'h1);
                chk("rst_sram_addr", 32'(sram_addr), 32'h0);
                chk("rst_ready", 32'(bus.ready), 32'(!(bus.rd_en || bus.wr_en)));
                chk("rst_dq_released", 32'(sram_dq), 32'(sram_q));
            end else begin
                wphase = m_wr && (m_pos == 1 || m_pos == 2);
                chk("ready", 32'(bus.ready),
                    (m_pos < 0) ? 32'(!(bus.rd_en || bus.wr_en)) : 32'(m_pos == 6));
                chk("we_n", 32'(sram_we_n), 32'(!wphase));
                chk("oe_n", 32'(sram_oe_n), 32'(wphase));
                chk("ce_ub_lb", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'h0);
                if (m_pos == 1 || m_pos == 2)
                    chk("sram_addr", 32'(sram_addr), 32'({m_wa, m_pos == 2}));
                if (wphase)
                    chk("dq_write", 32'(sram_dq), (m_pos == 1) ? 32'(m_d[15:0]) : 32'(m_d[31:16]));
                else
                    chk("dq_released", 32'(sram_dq), 32'(sram_q));
                chk("readData", bus.readData, exp_rd);
            end
        end else begin
            if (!rst_n) begin
                m_pos  = -1;
                exp_rd = '0;
            end else if (m_pos < 0) begin
                if (bus.rd_en || bus.wr_en) begin
                    m_wr  = bus.wr_en;
                    m_wa  = word_index(bus.address);
                    m_d   = bus.writeData;
                    m_pos = 1;
                end
            end else begin
                word = ref_word(m_wa);
                if (m_pos == 1 && !m_wr) exp_rd[15:0] = word[15:0];
                if (m_pos == 2) begin
                    if (m_wr) ref_mem[m_wa] = m_d;
                    else      exp_rd[31:16] = word[31:16];
                end
                m_pos = (m_pos == 6) ? -1 : m_pos + 1;
            end
        end
    end

    // One access, started at posedge+1 with the controller idle; returns at
    // posedge+1 after the completion cycle.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input bit keep, input bit drop,
                          output logic [17:0] a_lo, output logic [17:0] a_hi,
                          output logic [15:0] d_lo, output logic [15:0] d_hi,
                          output int low, output int wec);
        bit done;
        done = 1'b0;
        low  = 0;
        wec  = 0;
        a_lo = '0;
        a_hi = '0;
        d_lo = '0;
        d_hi = '0;
        bus.wr_en     = w;
        bus.rd_en     = r;
        bus.address   = a;
        bus.writeData = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (i == 1) begin a_lo = sram_addr; d_lo = sram_dq; end
                if (i == 2) begin a_hi = sram_addr; d_hi = sram_dq; end
            end
            if (!sram_we_n) wec++;
            if (drop && i == 0 && !done) begin
                @(posedge clk);
                #1;
                bus.wr_en     = 1'b0;
                bus.rd_en     = 1'b0;
                bus.address   = $urandom;
                bus.writeData = $urandom;
            end
        end
        if (!done) chk("access_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        if (!keep) begin
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] a_lo, a_hi;
        logic [15:0] d_lo, d_hi;
        int          low, wec;

        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.address   = '0;
        bus.writeData = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'h1);
        chk("reset_readData", bus.readData, 32'h0);
        chk("reset_we_n", 32'(sram_we_n), 32'h1);
        chk("reset_addr", 32'(sram_addr), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store 0xDEADBEEF at the segment base.
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("w1024_addr_lo", 32'(a_lo), 32'h0);
        chk("w1024_addr_hi", 32'(a_hi), 32'h1);
        chk("w1024_dq_lo", 32'(d_lo), 32'hBEEF);
        chk("w1024_dq_hi", 32'(d_hi), 32'hDEAD);
        chk("w1024_ready_low", 32'(low), 32'd6);
        chk("w1024_we_cycles", 32'(wec), 32'd2);
        chk("w1024_mem0", 32'(sram_mem[0]), 32'hBEEF);
        chk("w1024_mem1", 32'(sram_mem[1]), 32'hDEAD);

        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("r1024_data", bus.readData, 32'hDEADBEEF);
        chk("r1024_we_cycles", 32'(wec), 32'd0);

        access(1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("w1032_addr_lo", 32'(a_lo), 32'd4);
        chk("w1032_addr_hi", 32'(a_hi), 32'd5);
        chk("w1032_mem4", 32'(sram_mem[4]), 32'h5678);
        chk("w1032_mem5", 32'(sram_mem[5]), 32'h1234);

        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("r1028_addr_lo", 32'(a_lo), 32'd2);
        chk("r1028_addr_hi", 32'(a_hi), 32'd3);
        chk("r1028_data", bus.readData, 32'h0);

        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);

        // Both requests: the write must win and readData must not move.
        access(1'b1, 1'b1, 32'd1036, 32'h0000A5A5, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("both_we_cycles", 32'(wec), 32'd2);
        chk("both_readData_held", bus.readData, 32'hDEADBEEF);
        chk("both_mem6", 32'(sram_mem[6]), 32'hA5A5);
        chk("both_mem7", 32'(sram_mem[7]), 32'h0);

        access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("r1036_data", bus.readData, 32'h0000A5A5);

        // Reset during W2 of a read.
        bus.rd_en   = 1'b1;
        bus.address = 32'd1024;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_readData", bus.readData, 32'h0);
        chk("midreset_we_n", 32'(sram_we_n), 32'h1);
        chk("midreset_addr", 32'(sram_addr), 32'h0);
        chk("midreset_ready_req", 32'(bus.ready), 32'h0);
        chk("midreset_dq_released", 32'(sram_dq), 32'(sram_q));
        bus.rd_en = 1'b0;
        #1;
        chk("midreset_ready_idle", 32'(bus.ready), 32'h1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("postreset_ready_low", 32'(low), 32'd6);
        chk("postreset_data", bus.readData, 32'h12345678);

        // Two loads held back to back.
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("b2b_first_low", 32'(low), 32'd6);
        chk("b2b_first_data", bus.readData, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b0, a_lo, a_hi, d_lo, d_hi, low, wec);
        chk("b2b_second_low", 32'(low), 32'd6);
        chk("b2b_second_data", bus.readData, 32'h0000A5A5);

        // Randomized traffic; the model process checks every cycle.
        for (int n = 0; n < 200; n++) begin
            logic        w, r;
            logic [31:0] a, d;
            int          sel, gap;
            bit          keep, drop;
            sel  = $urandom_range(0, 3);
            w    = (sel == 0 || sel == 2);
            r    = (sel != 0);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'd1024 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            d    = $urandom;
            gap  = $urandom_range(0, 2);
            keep = (gap == 0) && ($urandom_range(0, 1) == 1);
            drop = !keep && ($urandom_range(0, 3) == 0);
            access(w, r, a, d, keep, drop, a_lo, a_hi, d_lo, d_hi, low, wec);
            chk("rand_ready_low", 32'(low), 32'd6);
            chk("rand_we_cycles", 32'(wec), w ? 32'd2 : 32'd0);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
